uart_alu_ctrl: RTL



---
 rtl/uart_pkg.sv | 28 ++
 rtl/frame_timeout.sv | 37 +++
 rtl/uart_alu_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the UART command sequencer and its ALU
//
// Purpose: state encoding, default widths and opcode values shared by
//          uart_alu_ctrl, frame_timeout and the external ALU.
// Ports:   none (package).
package uart_pkg;

  localparam int DBIT_DEF = 8;
  localparam int OP_W_DEF = 6;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SEND   = 3'd4
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/frame_timeout.sv
// rtl/frame_timeout.sv - inter-byte idle counter with clear, enable and expire
//
// Purpose: counts enabled idle cycles; expire fires combinationally in the
//          cycle the count sits at TMO_CYC-1 while still enabled, and the
//          counter wraps back to 0 on that edge.
// Ports:   clk, reset (async, active-high)
//          clear  - force count to 0 (wins over enable)
//          enable - count this cycle
//          expire - idle budget exhausted this cycle
module frame_timeout #(
  parameter int TMO_CYC = 50_000_000,
  parameter int TMO_W   = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] cnt;

  assign expire = enable && !clear && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || expire) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - RX-frame to ALU to TX-byte command sequencer
//
// Purpose: pops operand A, operand B and opcode from the RX FIFO, presents
//          them to an external combinational ALU, registers the result and
//          pushes it into the TX FIFO. Partial frames are dropped after an
//          inter-byte timeout.
// Ports:   clk, reset (async, active-high)
//          rx_empty, r_data, rd_uart  - RX FIFO read side
//          tx_full, wr_uart, w_data   - TX FIFO write side
//          alu_a, alu_b, alu_op       - registered ALU operands
//          alu_result                 - combinational ALU output
//          busy                       - high while not waiting for a new frame
//          frame_err                  - one-cycle pulse on timeout discard
module uart_alu_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int TMO_CYC = 50_000_000,
  parameter int TMO_W   = 26
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  output logic [DBIT-1:0] alu_a,
  output logic [DBIT-1:0] alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [DBIT-1:0] alu_result,
  output logic            busy,
  output logic            frame_err
);

  state_t state, state_nxt;

  logic            in_get, in_mid, pop;
  logic            tmo_clear, tmo_enable, tmo_expire;
  logic [DBIT-1:0] alu_a_nxt, alu_b_nxt, w_data_nxt;
  logic [OP_W-1:0] alu_op_nxt;
  logic            wr_nxt, err_nxt, busy_nxt;

  assign in_get = (state == GET_A) || (state == GET_B) || (state == GET_OP);
  assign in_mid = (state == GET_B) || (state == GET_OP);

  // The pop strobe has to coincide with the edge that latches r_data, so it
  // is decoded from the state register and rx_empty rather than registered.
  // Gating with reset keeps it low while the block is held in reset.
  assign pop     = in_get && !rx_empty && !reset;
  assign rd_uart = pop;

  // Only the middle of a frame is timed; any pop or leaving GET_B/GET_OP
  // restarts the idle budget.
  assign tmo_clear  = !in_mid || pop;
  assign tmo_enable = in_mid && rx_empty;

  frame_timeout #(
    .TMO_CYC(TMO_CYC),
    .TMO_W  (TMO_W)
  ) u_frame_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (tmo_clear),
    .enable(tmo_enable),
    .expire(tmo_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= GET_A;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      GET_A:  if (pop) state_nxt = GET_B;
      GET_B:  if (pop) state_nxt = GET_OP; else if (tmo_expire) state_nxt = GET_A;
      GET_OP: if (pop) state_nxt = EXEC;   else if (tmo_expire) state_nxt = GET_A;
      EXEC:   state_nxt = SEND;
      SEND:   if (!tx_full) state_nxt = GET_A;
      default: state_nxt = GET_A;
    endcase
  end

  // Next values for the registered outputs. wr_uart is raised on the edge
  // leaving SEND; tx_full is only ever raised by our own pushes, so the
  // room seen in SEND is still there for the following cycle's push.
  always_comb begin
    alu_a_nxt  = alu_a;
    alu_b_nxt  = alu_b;
    alu_op_nxt = alu_op;
    w_data_nxt = w_data;
    wr_nxt     = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      GET_A:  if (pop) alu_a_nxt = r_data;
      GET_B: begin
        if (pop) alu_b_nxt = r_data;
        else if (tmo_expire) err_nxt = 1'b1;
      end
      GET_OP: begin
        if (pop) alu_op_nxt = r_data[OP_W-1:0];
        else if (tmo_expire) err_nxt = 1'b1;
      end
      EXEC:   w_data_nxt = alu_result;
      SEND:   if (!tx_full) wr_nxt = 1'b1;
      default: ;
    endcase
    busy_nxt = (state_nxt != GET_A);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      w_data    <= '0;
      wr_uart   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      alu_a     <= alu_a_nxt;
      alu_b     <= alu_b_nxt;
      alu_op    <= alu_op_nxt;
      w_data    <= w_data_nxt;
      wr_uart   <= wr_nxt;
      frame_err <= err_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule
